// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: instruction
// encodings, LSU state encoding, byte-enable constants and small helpers
// also used by the decoder.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    // Words need addr[1:0]=00, halves need addr[0]=0, bytes always fit.
    function automatic logic is_aligned(input op_e op, input logic [1:0] addr_lo);
        logic ok;
        case (op)
            OP_LW, OP_SW:         ok = (addr_lo == 2'b00);
            OP_LH, OP_LHU, OP_SH: ok = (addr_lo[0] == 1'b0);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/half/word from a little-endian read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_extract
    import mips_mem_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        byte_sel = rdata_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = '0;
        case (op_i)
            OP_LW:   result_o = rdata_i;
            OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result_o = {16'h0000, half_sel};
            OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result_o = {24'h000000, byte_sel};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_store_align.sv
// Produces byte enables and lane-replicated write data for a store;
// loads get all four enables and no write data.
module lsu_store_align
    import mips_mem_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    // Enable pattern and replication per store width.
    always_comb begin
        be_o    = BE_WORD;
        wdata_o = '0;
        case (op_i)
            OP_SW: wdata_o = wdata_i;
            OP_SH: begin
                be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_o = {2{wdata_i[15:0]}};
            end
            OP_SB: begin
                be_o    = BE_BYTE0 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, request/acknowledge bus
// master with acknowledge timeout, and registered load result.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] exc_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

    lsu_state_e       state_q;
    op_e              op_q;
    logic [1:0]       addr_lo_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      rdata_q;
    logic             rdata_valid_q;
    logic             exc_adel_q;
    logic             exc_ades_q;
    logic             exc_bus_q;
    logic [31:0]      exc_pc_q;

    op_e         op_in;
    logic        aligned;
    logic        issue;
    logic        timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_result;

    assign op_in   = op_e'(op_type);
    assign aligned = is_aligned(op_in, addr[1:0]);
    assign issue   = (state_q == ST_IDLE) && op_valid && aligned;
    assign timeout = (state_q == ST_BUSY) && !mem_ack && (cnt_q == CNT_LIMIT);

    lsu_store_align u_store_align (
        .op_i      (op_in),
        .addr_lo_i (addr[1:0]),
        .wdata_i   (wdata),
        .be_o      (st_be),
        .wdata_o   (st_wdata)
    );

    lsu_load_extract u_load_extract (
        .op_i      (op_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (mem_rdata),
        .result_o  (ld_result)
    );

    // Pipeline freeze: issue cycle, then every BUSY cycle until ack or timeout.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            if (issue)
                stall = 1'b1;
            else if ((state_q == ST_BUSY) && !mem_ack && !timeout)
                stall = 1'b1;
        end
    end

    // Control FSM with registered bus, result and exception outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LW;
            addr_lo_q     <= '0;
            pc_q          <= '0;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            exc_adel_q    <= 1'b0;
            exc_ades_q    <= 1'b0;
            exc_bus_q     <= 1'b0;
            exc_pc_q      <= '0;
        end else begin
            rdata_valid_q <= 1'b0;
            exc_adel_q    <= 1'b0;
            exc_ades_q    <= 1'b0;
            exc_bus_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (aligned) begin
                            state_q     <= ST_BUSY;
                            op_q        <= op_in;
                            addr_lo_q   <= addr[1:0];
                            pc_q        <= pc;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= !is_load(op_in);
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= st_be;
                            mem_wdata_q <= st_wdata;
                        end else begin
                            exc_adel_q <= is_load(op_in);
                            exc_ades_q <= !is_load(op_in);
                            exc_pc_q   <= pc;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack || timeout) begin
                        state_q     <= ST_IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        if (mem_ack) begin
                            if (is_load(op_q)) begin
                                rdata_q       <= ld_result;
                                rdata_valid_q <= 1'b1;
                            end
                        end else begin
                            exc_bus_q <= 1'b1;
                            exc_pc_q  <= pc_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign exc_adel    = exc_adel_q;
    assign exc_ades    = exc_ades_q;
    assign exc_bus     = exc_bus_q;
    assign exc_pc      = exc_pc_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a word-array memory model
// and arithmetic reference functions for alignment, enables and extension.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    localparam int ACK_TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_type = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic [31:0] exc_pc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [16];

    load_store_unit #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .addr(addr), .wdata(wdata), .pc(pc), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .exc_pc(exc_pc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit ref_is_load(input op_e op);
        return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
    endfunction

    function automatic bit ref_aligned(input op_e op, input logic [31:0] a);
        if (op == OP_LW || op == OP_SW) return (a % 4) == 0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_be(input op_e op, input logic [31:0] a);
        if (op == OP_SH) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        if (op == OP_SB) return 4'(1 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input op_e op, input logic [31:0] w);
        if (op == OP_SH) return (w & 32'hFFFF) * 32'h0001_0001;
        if (op == OP_SB) return (w & 32'hFF) * 32'h0101_0101;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input op_e op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            OP_LW:   return w;
            OP_LBU:  return b;
            OP_LB:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            OP_LHU:  return h;
            OP_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction. waits = cycles without ack before the ack;
    // waits > ACK_TO means the memory never answers.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] p, input int waits,
                          output logic [31:0] got_rdata, output int stall_cycles);
        bit ld, al;
        int idx;
        logic [3:0] ebe;
        logic [31:0] ewd, word, eres;
        ld = ref_is_load(op);
        al = ref_aligned(op, a);
        idx = int'((a >> 2) % 16);
        ebe = ref_be(op, a);
        ewd = ref_wdata(op, wd);
        word = mem_model[idx];
        eres = ref_load(op, a, word);
        stall_cycles = 0;

        op_valid = 1'b1; op_type = op; addr = a; wdata = wd; pc = p; mem_ack = 1'b0;
        #1;
        checks++; if (stall !== al) begin errors++; $display("FAIL issue_stall: got %b expected %b", stall, al); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL issue_req: got %b expected 0", mem_req); end
        if (stall) stall_cycles++;
        tick();

        if (!al) begin
            op_valid = 1'b0;
            checks++; if (exc_adel !== ld) begin errors++; $display("FAIL exc_adel: got %b expected %b", exc_adel, ld); end
            checks++; if (exc_ades !== !ld) begin errors++; $display("FAIL exc_ades: got %b expected %b", exc_ades, !ld); end
            checks++; if (exc_pc !== p) begin errors++; $display("FAIL misalign_pc: got %h expected %h", exc_pc, p); end
            checks++; if ({mem_req, rdata_valid, exc_bus} !== 3'b000) begin errors++; $display("FAIL misalign_quiet: got %b expected 000", {mem_req, rdata_valid, exc_bus}); end
            got_rdata = rdata;
            return;
        end

        for (int i = 0; i <= ACK_TO; i++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL busy_req: got %b expected 1 (cycle %0d)", mem_req, i); end
            checks++; if (mem_we !== !ld) begin errors++; $display("FAIL busy_we: got %b expected %b", mem_we, !ld); end
            checks++; if (mem_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL busy_addr: got %h expected %h", mem_addr, a & 32'hFFFF_FFFC); end
            checks++; if (mem_be !== ebe) begin errors++; $display("FAIL busy_be: got %b expected %b", mem_be, ebe); end
            if (!ld) begin
                checks++; if (mem_wdata !== ewd) begin errors++; $display("FAIL busy_wdata: got %h expected %h", mem_wdata, ewd); end
            end
            mem_ack = (i == waits);
            mem_rdata = ld ? word : $urandom;
            #1;
            checks++; if (stall !== !(i == waits || i == ACK_TO)) begin errors++; $display("FAIL busy_stall: got %b expected %b (cycle %0d)", stall, !(i == waits || i == ACK_TO), i); end
            if (stall) stall_cycles++;
            tick();
            mem_ack = 1'b0;
            if (i == waits) break;
        end
        op_valid = 1'b0;

        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b expected 0", mem_req); end
        if (waits <= ACK_TO) begin
            checks++; if (rdata_valid !== ld) begin errors++; $display("FAIL done_rvalid: got %b expected %b", rdata_valid, ld); end
            if (ld) begin
                checks++; if (rdata !== eres) begin errors++; $display("FAIL done_rdata: got %h expected %h", rdata, eres); end
            end
            checks++; if ({exc_adel, exc_ades, exc_bus} !== 3'b000) begin errors++; $display("FAIL done_noexc: got %b expected 000", {exc_adel, exc_ades, exc_bus}); end
            if (!ld) begin
                for (int k = 0; k < 4; k++)
                    if (ebe[k]) mem_model[idx][8*k +: 8] = ewd[8*k +: 8];
            end
        end else begin
            checks++; if (exc_bus !== 1'b1) begin errors++; $display("FAIL timeout_bus: got %b expected 1", exc_bus); end
            checks++; if (exc_pc !== p) begin errors++; $display("FAIL timeout_pc: got %h expected %h", exc_pc, p); end
            checks++; if ({rdata_valid, exc_adel, exc_ades} !== 3'b000) begin errors++; $display("FAIL timeout_quiet: got %b expected 000", {rdata_valid, exc_adel, exc_ades}); end
        end
        got_rdata = rdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b1; op_type = OP_LW; addr = 32'h1000; mem_ack = 1'b1;
        tick(); tick();
        checks++;
        if ({stall, rdata, rdata_valid, exc_adel, exc_ades, exc_bus, exc_pc, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b addr=%h be=%b rdata=%h expected all zero", stall, mem_req, mem_addr, mem_be, rdata);
        end
        reset = 1'b0; op_valid = 1'b0; mem_ack = 1'b0;
        tick();
        checks++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b expected 00", {stall, mem_req}); end
    endtask

    task automatic test_store();
        logic [31:0] r; int sc;
        run_op(OP_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_3000, 2, r, sc);
        checks++; if (sc != 3) begin errors++; $display("FAIL sb_stall_cycles: got %0d expected 3", sc); end
        checks++; if (mem_model[0][31:24] !== 8'hA5) begin errors++; $display("FAIL sb_model_write: got %h expected a5", mem_model[0][31:24]); end
        tick();
    endtask

    task automatic test_load();
        logic [31:0] r; int sc;
        mem_model[0] = 32'h12F4_5678;
        run_op(OP_LB, 32'h1002, 32'h0, 32'h3004, 0, r, sc);
        checks++; if (r !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb_value: got %h expected fffffff4", r); end
        checks++; if (sc != 1) begin errors++; $display("FAIL lb_stall_cycles: got %0d expected 1", sc); end
        tick();
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b expected 0", rdata_valid); end
        run_op(OP_LBU, 32'h1002, 32'h0, 32'h3008, 0, r, sc);
        checks++; if (r !== 32'h0000_00F4) begin errors++; $display("FAIL lbu_value: got %h expected 000000f4", r); end
        run_op(OP_LHU, 32'h1002, 32'h0, 32'h300C, 1, r, sc);
        checks++; if (r !== 32'h0000_12F4) begin errors++; $display("FAIL lhu_value: got %h expected 000012f4", r); end
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] r; int sc;
        run_op(OP_LW, 32'h1006, 32'h0, 32'h3008, 0, r, sc);
        checks++; if (sc != 0) begin errors++; $display("FAIL adel_stall: got %0d expected 0", sc); end
        tick();
        checks++; if ({exc_adel, mem_req} !== 2'b00) begin errors++; $display("FAIL adel_pulse_width: got %b expected 00", {exc_adel, mem_req}); end
        run_op(OP_SH, 32'h1001, 32'h1234, 32'h300C, 0, r, sc);
        tick();
    endtask

    task automatic test_timeout();
        logic [31:0] r; int sc;
        run_op(OP_SW, 32'h2004, 32'hDEAD_BEEF, 32'h4000, 99, r, sc);
        checks++; if (sc != ACK_TO + 1) begin errors++; $display("FAIL timeout_stall_cycles: got %0d expected %0d", sc, ACK_TO + 1); end
        run_op(OP_LW, 32'h2008, 32'h0, 32'h4004, 1, r, sc);
        run_op(OP_LH, 32'h200A, 32'h0, 32'h4008, ACK_TO, r, sc);
        tick();
    endtask

    task automatic test_reset_busy();
        op_valid = 1'b1; op_type = OP_LW; addr = 32'h1000; pc = 32'h5000; mem_ack = 1'b0;
        tick();
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req_before: got %b expected 1", mem_req); end
        reset = 1'b1;
        tick();
        checks++; if ({mem_req, rdata_valid, exc_adel, exc_ades, exc_bus} !== 5'b0) begin errors++; $display("FAIL rst_busy_after: got %b expected 00000", {mem_req, rdata_valid, exc_adel, exc_ades, exc_bus}); end
        reset = 1'b0; op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_idle_stall: got %b expected 0", stall); end
        tick();
        mem_ack = 1'b0;
        checks++; if ({mem_req, rdata_valid, exc_bus} !== 3'b000) begin errors++; $display("FAIL idle_ack_ignored: got %b expected 000", {mem_req, rdata_valid, exc_bus}); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, wd; int sc;
        wd = $urandom;
        run_op(OP_SW, 32'h2000, wd, 32'h6000, 0, r, sc);
        run_op(OP_LW, 32'h2000, 32'h0, 32'h6004, 0, r, sc);
        checks++; if (r !== wd) begin errors++; $display("FAIL b2b_rdata: got %h expected %h", r, wd); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r; int sc, w;
        op_e op;
        for (int n = 0; n < 80; n++) begin
            op = op_e'($urandom_range(7, 0));
            w = ($urandom_range(9, 0) == 0) ? 99 : int'($urandom_range(ACK_TO, 0));
            run_op(op, 32'h2000 + $urandom_range(63, 0), $urandom, $urandom & 32'hFFFF_FFFC, w, r, sc);
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
